// File: rtl/demux4_pkg.sv
// Shared types and helpers for the 4-channel demux dispatcher.
package demux4_pkg;

  localparam int NUM_CH = 4;
  localparam int CH_W   = 2;

  // IDLE: nothing held; HOLD: a word waits in the output register.
  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  // Channel index to one-hot strobe.
  function automatic logic [NUM_CH-1:0] ch_onehot(input logic [CH_W-1:0] ch);
    ch_onehot = NUM_CH'(1) << ch;
  endfunction

endpackage

// File: rtl/demux4_dispatcher_if.sv
// Upstream valid/ready port plus the four-channel downstream strobe bus.
interface demux4_dispatcher_if
  import demux4_pkg::*;
#(
  parameter int DATA_W = 8
);

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CH_W-1:0]   in_sel;
  logic [NUM_CH-1:0] out_valid;
  logic [NUM_CH-1:0] out_ready;
  logic [DATA_W-1:0] out_data;

  // Environment side: produces words and channel readies.
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );

  // Dispatcher side.
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/demux4_cnt.sv
// Single wrapping delivery counter.
module demux4_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: wraps naturally at 2^CNT_W.
  always_comb begin
    cnt_d = cnt_q;
    if (inc_i) cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/demux4_dispatcher.sv
// One-entry dispatcher: accepts a word, routes it to one of four channels
// (addressed or round-robin), holds it until that channel is ready, and
// counts deliveries per channel.
module demux4_dispatcher
  import demux4_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    mode,
  demux4_dispatcher_if.slave      bus,
  output logic [CH_W-1:0]         sel_q,
  output logic                    busy,
  output logic [NUM_CH*CNT_W-1:0] cnt_flat
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CH_W-1:0]   rr_q, rr_d;

  logic              hold;
  logic              tgt_rdy;
  logic              deliver;
  logic              in_ready;
  logic              accept;
  logic [CH_W-1:0]   dest;
  logic [NUM_CH-1:0] deliv_vec;

  // Handshake decode and next-state; a delivery and an accept may share a
  // cycle, in which case the register is simply reloaded and stays in HOLD.
  always_comb begin
    hold     = (state_q == HOLD);
    tgt_rdy  = bus.out_ready[ch_q];
    deliver  = hold & tgt_rdy;
    in_ready = en & (~hold | tgt_rdy);
    accept   = bus.in_valid & in_ready;
    dest     = mode ? rr_q : bus.in_sel;

    state_d  = state_q;
    data_d   = data_q;
    ch_d     = ch_q;
    rr_d     = rr_q;

    if (accept) begin
      state_d = HOLD;
      data_d  = bus.in_data;
      ch_d    = dest;
      if (mode) rr_d = rr_q + CH_W'(1);
    end else if (deliver) begin
      state_d = IDLE;
    end
  end

  // State, held word, its channel and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      ch_q    <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      rr_q    <= rr_d;
    end
  end

  // Strobes come from registered state only, so reset clears them at once.
  assign bus.out_valid = hold ? ch_onehot(ch_q) : '0;
  assign bus.out_data  = data_q;
  assign bus.in_ready  = in_ready;
  assign sel_q         = ch_q;
  assign busy          = hold;
  assign deliv_vec     = deliver ? ch_onehot(ch_q) : '0;

  for (genvar n = 0; n < NUM_CH; n++) begin : g_cnt
    demux4_cnt #(
      .CNT_W (CNT_W)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc_i (deliv_vec[n]),
      .cnt_o (cnt_flat[n*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/demux4_dispatcher.md
# demux4_dispatcher

Sequencing controller for the 1-to-4 demultiplexer datapath. It accepts data words over a valid/ready handshake, chooses a destination channel, either from an explicit select or by round-robin, and holds each word in a one-entry register until the chosen channel takes it. It produces the one-hot channel strobes that the demux enable/select decode used to generate combinationally, and it keeps per-channel delivery counters.

## Interface
Parameters:
- DATA_W, 8, width of data word
- CNT_W, 8, width of each per-channel delivery counter

Ports:
- clk  in  1  single clock; all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- en  in  1  dispatcher enable; 0 blocks new accepts
- mode  in  1  0 = addressed (use in_sel), 1 = round-robin
- in_valid  in  1  upstream word present
- in_ready  out  1  dispatcher can accept this cycle
- in_data  in  DATA_W  upstream word
- in_sel  in  2  destination channel in addressed mode ({s1,s0})
- out_valid  out  4  one-hot channel strobe, bit n = channel n
- out_ready  in  4  per-channel ready
- out_data  out  DATA_W  held word, shared by all channels
- sel_q  out  2  channel of held word
- busy  out  1  word held (state HOLD)
- cnt_flat  out  4*CNT_W  delivery counters, channel n at [n*CNT_W +: CNT_W]

## Operation
- States: IDLE (no word held), HOLD (word in out_data awaiting out_ready[sel_q]).
- in_ready = en & (state==IDLE | out_ready[sel_q]). The dispatcher accepts a word when in_valid & in_ready.
- Destination on accept: mode=0 -> in_sel; mode=1 -> rr_ptr. rr_ptr advances by 1 mod 4 on every round-robin accept. It is not advanced in addressed mode.
- Delivery happens when state==HOLD & out_ready[sel_q]. On delivery, cnt[sel_q] increments and wraps modulo 2^CNT_W.
- Transitions:
  - IDLE -> HOLD on accept.
  - HOLD -> IDLE on delivery without accept.
  - HOLD -> HOLD on delivery with accept (back-to-back). The new word and sel are loaded and the old word counts as delivered.
  - HOLD stays in place while out_ready[sel_q]=0.
- out_valid = (state==HOLD) ? (4'b0001 << sel_q) : 4'b0000. It is never multi-hot.
- out_ready bits of non-selected channels are ignored.
- en=0 while in HOLD: the held word still delivers, no new accept occurs, and the state returns to IDLE.
- A mode change takes effect on the next accept. It does not re-route a held word.
- out_data and sel_q stay stable throughout HOLD until delivery.

## Timing
- Reset values (async assert, sync release): state=IDLE, out_valid=0, out_data=0, sel_q=0, busy=0, rr_ptr=0, all cnt=0, in_ready=en (combinational).
- Latency: a word accepted at edge k shows on out_valid/out_data after edge k (same cycle as busy=1).
- Throughput: 1 word/cycle when the target channel's ready is held high.
- in_ready is combinational from out_ready and en. There is no combinational path from in_valid to out_*.
- A counter increments at the edge that completes delivery.
- Reset mid-HOLD: the word is discarded, no count is made, and out_valid drops to 0 immediately on rst_n falling.

## Structure
- Package demux4_pkg: state enum (IDLE, HOLD), NUM_CH=4, CH_W=2, channel-to-one-hot function.
- Sub-module demux4_cnt: a single CNT_W wrap counter with inc input, instantiated 4 times. All other logic stays in the top module.

## Test plan
- Reset: rst_n=0 mid-HOLD with out_valid=4'b0100 -> out_valid=0, busy=0, cnt_flat=0 without waiting for a clock edge. After release, in_ready=1 when en=1.
- Addressed: mode=0, send 8'hA5 sel=3 with out_ready=4'b1000 -> out_valid=4'b1000, out_data=A5 one cycle later, cnt3=1, others 0.
- Round-robin streaming: mode=1, out_ready=4'hF, 8 back-to-back words -> destinations 0,1,2,3,0,1,2,3, in_ready stays 1, each cnt=2.
- Backpressure: sel=1, out_ready[1]=0 for 5 cycles -> out_valid=4'b0010 and out_data stable, in_ready=0. Raising out_ready[1] delivers the word and a pending word is accepted the same cycle.
- Enable: en=0 while HOLD -> the held word delivers, in_ready=0, and no further accept occurs despite in_valid=1. Re-enabling resumes from the unchanged rr_ptr.
- Counter wrap: CNT_W=8, 256 deliveries to channel 2 -> cnt2 returns to 0, no other counter changes.
